// File: rtl/mem_access_unit_if.sv
// Bundle of the control-unit request/response handshake and the byte-wide memory port.
// Ports: req_* / resp_* / busy face the control unit, mem_* face the main memory.
// slave = the access unit itself; master = the control unit plus memory side.
interface mem_access_unit_if;
   // control-unit side
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        busy;
   // memory side
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, busy, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, busy, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose: splits 16-bit word read/write requests into two big-endian byte accesses
//          (high byte at A, low byte at A+1 mod 2^ADDR_W) on a single-port byte memory.
// Latency: read response 3 cycles after acceptance, write response 2 cycles after.
// Backpressure: req_ready is high only in IDLE; requests offered while busy must be held.
// Ports: clk, reset (async active-high); bus = request/response handshake + memory port.
module mem_access_unit #(
   parameter int ADDR_W = 14
) (
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      RD_HI,
      RD_LO,
      RD_CAP,
      WR_HI,
      WR_LO
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   state_t            state;
   state_t            next_state;

   logic [ADDR_W-1:0] addr_a;       // latched address of the high byte
   logic [ADDR_W-1:0] addr_a1;      // low-byte address, wraps at 2^ADDR_W
   logic [15:0]       wdata_q;
   logic [7:0]        hi_q;         // high byte captured while fetching the low byte
   logic              resp_valid_q;
   logic [15:0]       resp_rdata_q;
   logic              accept;

   logic [15:0]       mem_addr_c;
   logic [7:0]        mem_wdata_c;
   logic              mem_we_c;

   // Zero-extend a memory byte address to the 16-bit bus.
   function automatic logic [15:0] widen(input logic [ADDR_W-1:0] a);
      logic [15:0] w;
      w = '0;
      w[ADDR_W-1:0] = a;
      return w;
   endfunction

   assign accept  = bus.req_valid && (state == IDLE);
   assign addr_a1 = addr_a + ADDR_ONE;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = bus.req_write ? WR_HI : RD_HI;
            end
         end
         RD_HI:   next_state = RD_LO;
         RD_LO:   next_state = RD_CAP;
         RD_CAP:  next_state = IDLE;
         WR_HI:   next_state = WR_LO;
         WR_LO:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- memory port
   // Decoded straight from the state so that an asynchronous reset drops mem_we
   // in the same instant, without waiting for a clock edge.
   always_comb begin
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      mem_we_c    = 1'b0;
      case (state)
         RD_HI: begin
            mem_addr_c = widen(addr_a);
         end
         RD_LO: begin
            mem_addr_c = widen(addr_a1);
         end
         WR_HI: begin
            mem_addr_c  = widen(addr_a);
            mem_wdata_c = wdata_q[15:8];
            mem_we_c    = 1'b1;
         end
         WR_LO: begin
            mem_addr_c  = widen(addr_a1);
            mem_wdata_c = wdata_q[7:0];
            mem_we_c    = 1'b1;
         end
         default: begin
            mem_addr_c  = '0;
            mem_wdata_c = '0;
            mem_we_c    = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   // mem_rdata lags the address by one edge: the byte at A is present during
   // RD_LO and the byte at A1 during RD_CAP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_a       <= '0;
         wdata_q      <= '0;
         hi_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         if (accept) begin
            addr_a  <= bus.req_addr[ADDR_W-1:0];
            wdata_q <= bus.req_wdata;
         end
         case (state)
            RD_LO: begin
               hi_q <= bus.mem_rdata;
            end
            RD_CAP: begin
               resp_rdata_q <= {hi_q, bus.mem_rdata};
               resp_valid_q <= 1'b1;
            end
            WR_LO: begin
               resp_valid_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.req_ready  = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_wdata  = mem_wdata_c;
   assign bus.mem_we     = mem_we_c;

endmodule
